// File: rtl/udp_echo_defs_pkg.sv
// rtl/udp_echo_defs_pkg.sv - shared encodings and width helper for the UDP echo buffer
package udp_echo_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_e;

    typedef enum logic [2:0] {
        DROP_NONE     = 3'd0,
        DROP_ZERO_LEN = 3'd1,
        DROP_TOO_LONG = 3'd2,
        DROP_NO_SPACE = 3'd3,
        DROP_NO_SLOT  = 3'd4,
        DROP_OVERRUN  = 3'd5
    } drop_reason_e;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/udp_echo_sdpram.sv
// rtl/udp_echo_sdpram.sv - 8-bit simple dual-port RAM, one-cycle registered read
module udp_echo_sdpram #(
    parameter int P_DEPTH = 4096,
    parameter int P_AW    = 12
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [P_AW-1:0] i_waddr,
    input  logic [7:0]      i_wdata,
    input  logic            i_re,
    input  logic [P_AW-1:0] i_raddr,
    output logic [7:0]      o_rdata
);
    logic [7:0] mem_q [P_DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_waddr] <= i_wdata;
        if (i_re) rdata_q <= mem_q[i_raddr];
    end

    assign o_rdata = rdata_q;
endmodule

// File: rtl/udp_echo_buffer.sv
// rtl/udp_echo_buffer.sv - store-and-forward UDP echo stage; UDP_ECHO_STATS_EN adds packet counters
module udp_echo_buffer
    import udp_echo_defs::*;
#(
    parameter int P_DATA_DEPTH = 4096,
    parameter int P_PKT_DEPTH  = 16,
    parameter int P_MAX_LEN    = 1472,
    parameter int P_GAP_CYCLES = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_recv_udp_data,
    input  logic [15:0] i_recv_udp_len,
    input  logic        i_recv_udp_last,
    input  logic        i_recv_udp_valid,
    input  logic        i_send_ready,
    output logic [7:0]  o_send_udp_data,
    output logic [15:0] o_send_udp_len,
    output logic        o_send_udp_last,
    output logic        o_send_udp_valid,
    output logic        o_drop,
    output logic        o_pkt_pending
`ifdef UDP_ECHO_STATS_EN
    ,
    output logic [15:0] o_rx_pkt_cnt,
    output logic [15:0] o_tx_pkt_cnt,
    output logic [15:0] o_drop_cnt
`endif
);
    localparam int AW = clog2(P_DATA_DEPTH);
    localparam int PW = AW + 1;
    localparam int FW = clog2(P_PKT_DEPTH);
    localparam int LW = FW + 1;
    localparam int GW = clog2(P_GAP_CYCLES) + 1;

    tx_state_e    state_q, state_d;
    drop_reason_e first_reason, rx_reason;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_shadow_q, wr_shadow_d, wr_commit_q, wr_commit_d, free;
    logic          rx_active_q, rx_active_d, rx_discard_q, rx_discard_d;
    logic [15:0]   rx_cnt_q, rx_cnt_d, tx_len_q, tx_len_d, tx_left_q, tx_left_d, rd_left_q, rd_left_d;
    logic [LW-1:0] lf_wp_q, lf_wp_d, lf_rp_q, lf_rp_d, lf_count;
    logic [15:0]   lf_mem_q [P_PKT_DEPTH];
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    data_q, data_d, ram_rdata;
    logic [15:0]   len_q, len_d, lf_push_len, lf_head;
    logic          last_q, last_d, valid_q, valid_d, drop_q, drop_d, pending_q, pending_d;
    logic          ram_we, ram_re, lf_push, lf_pop, lf_full;

    // Extra pointer bit keeps full and empty distinguishable.
    assign free     = PW'(P_DATA_DEPTH) - (wr_shadow_q - rd_ptr_q);
    assign lf_count = lf_wp_q - lf_rp_q;
    assign lf_full  = (lf_count == LW'(P_PKT_DEPTH));
    assign lf_head  = lf_mem_q[lf_rp_q[FW-1:0]];

    always_comb begin
        first_reason = DROP_NONE;
        if (i_recv_udp_len == 16'd0)                       first_reason = DROP_ZERO_LEN;
        else if (32'(i_recv_udp_len) > P_MAX_LEN)          first_reason = DROP_TOO_LONG;
        else if (32'(free) < 32'(i_recv_udp_len))          first_reason = DROP_NO_SPACE;
        else if (lf_full)                                  first_reason = DROP_NO_SLOT;
    end

    always_comb begin
        wr_shadow_d  = wr_shadow_q;
        wr_commit_d  = wr_commit_q;
        rx_active_d  = rx_active_q;
        rx_discard_d = rx_discard_q;
        rx_cnt_d     = rx_cnt_q;
        rx_reason    = DROP_NONE;
        ram_we       = 1'b0;
        lf_push      = 1'b0;
        lf_push_len  = rx_cnt_q + 16'd1;
        drop_d       = 1'b0;
        if (i_recv_udp_valid) begin
            if (rx_discard_q) begin
                if (i_recv_udp_last) begin
                    drop_d       = 1'b1;
                    rx_discard_d = 1'b0;
                end
            end else begin
                if (!rx_active_q)                rx_reason = first_reason;
                else if (rx_cnt_q >= i_recv_udp_len) rx_reason = DROP_OVERRUN;
                else if (free == '0)             rx_reason = DROP_NO_SPACE;
                if (rx_reason != DROP_NONE) begin
                    // Rewind so a partially written packet leaves no residue.
                    wr_shadow_d = wr_commit_q;
                    rx_active_d = 1'b0;
                    rx_cnt_d    = 16'd0;
                    if (i_recv_udp_last) drop_d = 1'b1;
                    else                 rx_discard_d = 1'b1;
                end else begin
                    ram_we      = 1'b1;
                    wr_shadow_d = wr_shadow_q + PW'(1);
                    if (i_recv_udp_last) begin
                        lf_push     = 1'b1;
                        wr_commit_d = wr_shadow_q + PW'(1);
                        rx_active_d = 1'b0;
                        rx_cnt_d    = 16'd0;
                    end else begin
                        rx_active_d = 1'b1;
                        rx_cnt_d    = rx_cnt_q + 16'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        rd_left_d = rd_left_q;
        tx_left_d = tx_left_q;
        tx_len_d  = tx_len_q;
        gap_d     = gap_q;
        ram_re    = 1'b0;
        lf_pop    = 1'b0;
        data_d    = 8'd0;
        len_d     = 16'd0;
        last_d    = 1'b0;
        valid_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((lf_count != '0) && i_send_ready) begin
                    lf_pop    = 1'b1;
                    ram_re    = 1'b1;
                    rd_ptr_d  = rd_ptr_q + PW'(1);
                    tx_len_d  = lf_head;
                    tx_left_d = lf_head;
                    rd_left_d = lf_head - 16'd1;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH, ST_SEND: begin
                valid_d   = 1'b1;
                data_d    = ram_rdata;
                len_d     = tx_len_q;
                last_d    = (tx_left_q == 16'd1);
                tx_left_d = tx_left_q - 16'd1;
                if (rd_left_q != 16'd0) begin
                    ram_re    = 1'b1;
                    rd_ptr_d  = rd_ptr_q + PW'(1);
                    rd_left_d = rd_left_q - 16'd1;
                end
                // GAP plus the IDLE pick cycle give P_GAP_CYCLES dead cycles on the output.
                if (tx_left_q == 16'd1) begin
                    state_d = ST_GAP;
                    gap_d   = GW'(P_GAP_CYCLES - 2);
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) state_d = ST_IDLE;
                else             gap_d   = gap_q - GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lf_wp_d   = lf_wp_q + LW'(lf_push);
        lf_rp_d   = lf_rp_q + LW'(lf_pop);
        pending_d = (lf_wp_d != lf_rp_d);
    end

    always_ff @(posedge i_clk) begin
        if (lf_push) lf_mem_q[lf_wp_q[FW-1:0]] <= lf_push_len;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            rd_ptr_q     <= '0;
            wr_shadow_q  <= '0;
            wr_commit_q  <= '0;
            rx_active_q  <= 1'b0;
            rx_discard_q <= 1'b0;
            rx_cnt_q     <= '0;
            tx_len_q     <= '0;
            tx_left_q    <= '0;
            rd_left_q    <= '0;
            lf_wp_q      <= '0;
            lf_rp_q      <= '0;
            gap_q        <= '0;
            data_q       <= '0;
            len_q        <= '0;
            last_q       <= 1'b0;
            valid_q      <= 1'b0;
            drop_q       <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_shadow_q  <= wr_shadow_d;
            wr_commit_q  <= wr_commit_d;
            rx_active_q  <= rx_active_d;
            rx_discard_q <= rx_discard_d;
            rx_cnt_q     <= rx_cnt_d;
            tx_len_q     <= tx_len_d;
            tx_left_q    <= tx_left_d;
            rd_left_q    <= rd_left_d;
            lf_wp_q      <= lf_wp_d;
            lf_rp_q      <= lf_rp_d;
            gap_q        <= gap_d;
            data_q       <= data_d;
            len_q        <= len_d;
            last_q       <= last_d;
            valid_q      <= valid_d;
            drop_q       <= drop_d;
            pending_q    <= pending_d;
        end
    end

    udp_echo_sdpram #(
        .P_DEPTH (P_DATA_DEPTH),
        .P_AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_waddr (wr_shadow_q[AW-1:0]),
        .i_wdata (i_recv_udp_data),
        .i_re    (ram_re),
        .i_raddr (rd_ptr_q[AW-1:0]),
        .o_rdata (ram_rdata)
    );

    assign o_send_udp_data  = data_q;
    assign o_send_udp_len   = len_q;
    assign o_send_udp_last  = last_q;
    assign o_send_udp_valid = valid_q;
    assign o_drop           = drop_q;
    assign o_pkt_pending    = pending_q;

`ifdef UDP_ECHO_STATS_EN
    logic [15:0] rx_pkt_cnt_q, rx_pkt_cnt_d, tx_pkt_cnt_q, tx_pkt_cnt_d, drop_cnt_q, drop_cnt_d;

    always_comb begin
        rx_pkt_cnt_d = rx_pkt_cnt_q;
        tx_pkt_cnt_d = tx_pkt_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        if (lf_push && (rx_pkt_cnt_q != 16'hffff)) rx_pkt_cnt_d = rx_pkt_cnt_q + 16'd1;
        if (last_d && (tx_pkt_cnt_q != 16'hffff))  tx_pkt_cnt_d = tx_pkt_cnt_q + 16'd1;
        if (drop_d && (drop_cnt_q != 16'hffff))    drop_cnt_d   = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_pkt_cnt_q <= '0;
            tx_pkt_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            rx_pkt_cnt_q <= rx_pkt_cnt_d;
            tx_pkt_cnt_q <= tx_pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign o_rx_pkt_cnt = rx_pkt_cnt_q;
    assign o_tx_pkt_cnt = tx_pkt_cnt_q;
    assign o_drop_cnt   = drop_cnt_q;
`endif
endmodule
